// File: rtl/sig_edge_detect.sv
// Multi-channel edge detector: per-channel synchroniser, debounce filter,
// selectable edge qualification, sticky pending flag and wrapping event count.
module sig_edge_detect #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         sig,
  input  logic [2*N-1:0]       mode,
  input  logic [N-1:0]         clr,
  output logic [N-1:0]         edge_pulse,
  output logic [N-1:0]         level,
  output logic [N-1:0]         pending,
  output logic                 any_pending,
  output logic [N*CNT_W-1:0]   count,
  output logic [1:0]           dbg_state
);

  localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int INIT_W = $clog2(SYNC_STAGES + 1);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [INIT_W-1:0]   init_cnt, init_cnt_nxt;
  logic [N-1:0]        sync_q [SYNC_STAGES];
  logic [N-1:0]        s;

  // Block FSM: INIT lets the sync chains fill, LOAD adopts their value silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_W'(SYNC_STAGES - 1)) begin
          state_nxt    = ST_LOAD;
          init_cnt_nxt = '0;
        end else begin
          init_cnt_nxt = init_cnt + INIT_W'(1);
        end
      end
      ST_LOAD: state_nxt = ST_RUN;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= sig;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic             lvl_q;
    logic             pulse_q;
    logic             pend_q;
    logic [DB_W-1:0]  db_cnt;
    logic [CNT_W-1:0] cnt_q;
    logic             upd;
    logic             qual;

    // A level update happens only after DEBOUNCE consecutive differing samples.
    assign upd  = (state == ST_RUN) && (s[i] != lvl_q) && (db_cnt == DB_W'(DEBOUNCE - 1));
    assign qual = upd && ((s[i] && mode[2*i]) || (!s[i] && mode[2*i+1]));

    always_ff @(posedge clk) begin
      if (rst) begin
        lvl_q   <= 1'b0;
        pulse_q <= 1'b0;
        pend_q  <= 1'b0;
        db_cnt  <= '0;
        cnt_q   <= '0;
      end else begin
        pulse_q <= qual;
        if (state == ST_LOAD) begin
          lvl_q  <= s[i];
          db_cnt <= '0;
        end else if (state == ST_RUN) begin
          if (s[i] == lvl_q) begin
            db_cnt <= '0;
          end else if (db_cnt == DB_W'(DEBOUNCE - 1)) begin
            lvl_q  <= s[i];
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        // A qualifying edge beats a simultaneous clear.
        if (qual) begin
          pend_q <= 1'b1;
          cnt_q  <= clr[i] ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end else if (clr[i]) begin
          pend_q <= 1'b0;
          cnt_q  <= '0;
        end
      end
    end

    assign level[i]                   = lvl_q;
    assign edge_pulse[i]              = pulse_q;
    assign pending[i]                 = pend_q;
    assign count[CNT_W*i +: CNT_W]    = cnt_q;
  end

  assign any_pending = |pending;

endmodule

// File: tb/tb_sig_edge_detect.sv
// Directed bench for sig_edge_detect: expected pulse events are queued by the
// driver and compared by a monitor when the cycle comes round.
module tb_sig_edge_detect;

  localparam int N           = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE    = 4;
  localparam int CNT_W       = 8;
  localparam int LAT         = SYNC_STAGES + DEBOUNCE;
  localparam int EW          = 3*N + N*CNT_W;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         sig;
  logic [2*N-1:0]       mode;
  logic [N-1:0]         clr;
  logic [N-1:0]         edge_pulse;
  logic [N-1:0]         level;
  logic [N-1:0]         pending;
  logic                 any_pending;
  logic [N*CNT_W-1:0]   count;
  logic [1:0]           dbg_state;

  sig_edge_detect #(
    .N(N), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .sig(sig), .mode(mode), .clr(clr),
    .edge_pulse(edge_pulse), .level(level), .pending(pending),
    .any_pending(any_pending), .count(count), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [EW-1:0] exp_q[$];
  int            exp_cyc_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input int at, input logic [N-1:0] p, input logic [N-1:0] l,
                          input logic [N-1:0] pe, input logic [N*CNT_W-1:0] c);
    exp_cyc_q.push_back(at);
    exp_q.push_back({p, l, pe, c});
  endtask

  task automatic check_state(input string name, input logic [N-1:0] l,
                             input logic [N-1:0] pe, input logic [N*CNT_W-1:0] c);
    check(name, {level, pending, count}, {l, pe, c});
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      logic [EW-1:0] e;
      void'(exp_cyc_q.pop_front());
      e = exp_q.pop_front();
      check("pulse_event", {edge_pulse, level, pending, count}, e);
    end else if (edge_pulse !== '0) begin
      check("stray_pulse", edge_pulse, '0);
    end
  end

  initial begin
    int c;
    rst  = 1'b1;
    sig  = 4'b0101;
    mode = 8'hFF;
    clr  = '0;
    tick(2);
    check("reset_state", dbg_state, 2'd0);
    check("reset_outputs", {level, pending, any_pending, count}, '0);

    // Bring-up with inputs already high: no spurious edges.
    rst = 1'b0;
    tick(1);
    check("init_state", dbg_state, 2'd0);
    tick(1);
    check("load_state", dbg_state, 2'd1);
    tick(1);
    check("run_state", dbg_state, 2'd2);
    check_state("load_level", 4'b0101, 4'b0000, '0);
    tick(10);
    check_state("load_level_hold", 4'b0101, 4'b0000, '0);

    // ch0 rise-only
    mode = 8'h6D;
    sig[0] = 1'b0;
    tick(8);
    check_state("ch0_fall_ignored", 4'b0100, 4'b0000, '0);
    sig[0] = 1'b1;
    push_exp(cyc + LAT, 4'b0001, 4'b0101, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd1});
    tick(8);
    sig[0] = 1'b0;
    tick(8);
    check_state("ch0_fall_no_pulse", 4'b0100, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd1});

    // ch1 both edges: short glitch filtered, 4-cycle pulse gives two edges
    sig[1] = 1'b1;
    tick(3);
    sig[1] = 1'b0;
    tick(8);
    check_state("ch1_glitch3", 4'b0100, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd1});
    sig[1] = 1'b1;
    c = cyc;
    push_exp(c + LAT,      4'b0010, 4'b0110, 4'b0011, {8'd0, 8'd0, 8'd1, 8'd1});
    push_exp(c + LAT + 4,  4'b0010, 4'b0100, 4'b0011, {8'd0, 8'd0, 8'd2, 8'd1});
    tick(4);
    sig[1] = 1'b0;
    tick(10);
    check_state("ch1_two_edges", 4'b0100, 4'b0011, {8'd0, 8'd0, 8'd2, 8'd1});

    // ch2 fall-only, 300 falls wrap the 8-bit counter to 44
    for (int k = 1; k <= 300; k++) begin
      sig[2] = 1'b0;
      push_exp(cyc + LAT, 4'b0100, 4'b0000, 4'b0111, {8'd0, 8'(k), 8'd2, 8'd1});
      tick(5);
      sig[2] = 1'b1;
      tick(5);
    end
    tick(4);
    check_state("ch2_wrap", 4'b0100, 4'b0111, {8'd0, 8'd44, 8'd2, 8'd1});

    // clear coinciding with a qualifying edge, then clear again
    sig[2] = 1'b0;
    push_exp(cyc + LAT, 4'b0100, 4'b0000, 4'b0111, {8'd0, 8'd1, 8'd2, 8'd1});
    tick(5);
    clr[2] = 1'b1;
    tick(2);
    check_state("ch2_clr_after", 4'b0000, 4'b0011, {8'd0, 8'd0, 8'd2, 8'd1});
    clr = '0;
    sig[2] = 1'b1;
    tick(8);

    // all channels rise-only, simultaneous rise
    mode = 8'h55;
    sig  = 4'b0000;
    tick(8);
    check_state("all_low", 4'b0000, 4'b0011, {8'd0, 8'd0, 8'd2, 8'd1});
    sig = 4'b1111;
    push_exp(cyc + LAT, 4'b1111, 4'b1111, 4'b1111, {8'd1, 8'd1, 8'd3, 8'd2});
    tick(8);
    check("any_pending_set", any_pending, 1'b1);
    clr = 4'b0111;
    tick(1);
    check_state("clr_low3", 4'b1111, 4'b1000, {8'd1, 8'd0, 8'd0, 8'd0});
    check("any_pending_ch3", any_pending, 1'b1);
    clr = 4'b1000;
    tick(1);
    check("any_pending_clear", any_pending, 1'b0);
    check_state("clr_ch3", 4'b1111, 4'b0000, '0);
    clr = '0;

    // reset while ch3 is mid-debounce (counter at 2)
    mode = 8'hD5;
    sig[3] = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_mid_init", dbg_state, 2'd0);
    tick(3);
    check("rst_mid_run", dbg_state, 2'd2);
    check_state("rst_mid_level", 4'b0111, 4'b0000, '0);
    tick(12);
    check_state("rst_mid_settled", 4'b0111, 4'b0000, '0);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sig_edge_detect.md
Name: sig_edge_detect

Overview:
Multi-channel, parametrised edge detector. It is the successor to the single-signal positive-edge detector. Each channel synchronises an asynchronous input and applies a debounce filter. It then emits a one-cycle pulse on a per-channel selectable edge type (rise, fall, both, off), holds a sticky pending flag and keeps a wrapping event count. It sits between board I/O (buttons, external triggers, frame/line strobes) and control logic in the clk domain.

Parameters:
N, 4, number of independent channels (>=1)
SYNC_STAGES, 2, synchroniser flip-flop depth per channel (>=2)
DEBOUNCE, 4, consecutive stable cycles required before the filtered level changes (>=1; 1 = no filtering)
CNT_W, 8, width of each per-channel event counter

Ports:
clk  in  1  sole clock; all logic rising-edge
rst  in  1  synchronous, active-high reset
sig  in  N  asynchronous raw inputs, bit i = channel i
mode  in  2*N  per-channel edge select, bits [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr  in  N  per-channel clear of pending and count, level-sensitive, sampled each cycle
edge_pulse  out  N  one-cycle pulse per qualifying edge
level  out  N  debounced, synchronised level
pending  out  N  sticky flag, set by edge_pulse, cleared by clr
any_pending  out  1  OR of pending (combinational from registers)
count  out  N*CNT_W  per-channel event counters, channel i at [CNT_W*(i+1)-1 : CNT_W*i]

Behaviour:
- Reset (rst=1 at a clk edge): sync chains, level, edge_pulse, pending and count all go to 0. Debounce counters go to 0. Block FSM enters INIT. any_pending=0.
- Block FSM:
  - INIT: an init counter runs SYNC_STAGES cycles so the sync chains fill with the real input value.
  - LOAD: one cycle. level <= sync output for every channel, with no pulse, no pending and no count change. This stops a high input at reset from producing a spurious rising edge.
  - RUN: normal operation. RUN persists until rst.
- edge_pulse=0 in INIT and LOAD. clr is still honoured in all states.
- Synchroniser: chain of SYNC_STAGES flops; s_i = last stage.
- Debounce, per channel, in RUN:
  - s_i == level_i: debounce counter <= 0.
  - Otherwise, counter == DEBOUNCE-1: level_i <= s_i, counter <= 0, and a qualifying edge is evaluated in the same cycle.
  - Otherwise: counter increments.
  - A glitch shorter than DEBOUNCE cycles at the sync output never changes level.
- Qualification: rising edge (level 0->1) qualifies if mode bit0=1; falling edge (1->0) qualifies if mode bit1=1. mode is sampled in the cycle level updates. A mode change takes effect on the next update.
- edge_pulse_i is registered and asserts in the same cycle level_i changes, for exactly one cycle.
- Latency, sig change to edge_pulse/level: SYNC_STAGES + DEBOUNCE clock edges (defaults: 6).
- Maximum pulse rate per channel: one per DEBOUNCE cycles.
- pending_i:
  - Set on edge_pulse_i.
  - Cleared when clr_i=1.
  - Simultaneous qualifying edge and clr_i: pending_i=1 (set wins).
- count_i:
  - Increments by 1 per edge_pulse_i and wraps from 2^CNT_W-1 to 0 with no flag.
  - clr_i=1 sets count_i <= 0.
  - Simultaneous qualifying edge and clr_i: count_i <= 1.
- Channels are fully independent. Simultaneous edges on all channels are all reported in the same cycle.
- rst mid-operation: returns to INIT regardless of debounce progress. In-flight edges are discarded, and no pulse is emitted for the level seen at LOAD.

Test Plan:
- Reset with sig=4'b0101, mode all 11 -> after INIT/LOAD, level=0101, edge_pulse never asserts, pending=0, counts=0.
- Ch0 mode=01, sig[0] 0->1 held -> edge_pulse[0] high exactly 1 cycle, 6 edges after change, level[0]=1, pending[0]=1, count0=1. Then 1->0 -> no pulse, level[0]=0.
- Ch1 mode=11, glitch of 3 sync cycles (DEBOUNCE=4) -> no level change, no pulse. Glitch held 4 cycles -> pulse, and a later return edge also pulses (count1=2).
- Ch2 mode=10, toggle 300 qualifying falls -> count2 wraps to 300-256=44. clr[2] asserted in the same cycle as a pulse -> pending[2]=1, count2=1. Next cycle with clr[2] still high -> pending[2]=0, count2=0.
- All channels mode=01, simultaneous rise on all -> edge_pulse=1111 in one cycle, any_pending=1. Clear ch0-2 only -> any_pending stays 1 until clr[3].
- Assert rst while ch3 is mid-debounce (counter=2) -> no pulse emitted. After INIT/LOAD, level[3] equals the current sig[3], count3=0.
